// File: rtl/sisc_mem_arb.sv
// Shares the single SISC memory port between instruction fetch and data
// accesses: round-robin arbitration, a data-side lock for SWP, and fixed-latency sequencing.
module sisc_mem_arb #(
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic       OWN_FETCH = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [3:0] CNT_LAST  = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_owner;
  logic       lock_hold;
  logic       lock_req;
  logic       grant_data;
  logic       grant_fetch;

  // Data wins when alone, when the port is locked to it, or when fetch went last.
  assign grant_data  = d_req && (!if_req || lock_hold || (last_owner == OWN_FETCH));
  assign grant_fetch = if_req && !grant_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= OWN_FETCH;
      last_owner <= OWN_DATA;
      lock_hold  <= 1'b0;
      lock_req   <= 1'b0;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_done     <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!d_req) begin
            lock_hold <= 1'b0;
          end
          if (grant_data) begin
            owner     <= OWN_DATA;
            lock_req  <= d_lock;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            d_gnt     <= 1'b1;
            cnt       <= '0;
            state     <= ACCESS;
          end else if (grant_fetch) begin
            owner     <= OWN_FETCH;
            lock_req  <= 1'b0;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_en    <= 1'b1;
            if_gnt    <= 1'b1;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // The strobe cycle itself is not counted; latency runs from the cycle after it.
          if (mem_en) begin
            mem_en <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            if (owner == OWN_DATA) begin
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
              d_done <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if_done    <= 1'b0;
          d_done     <= 1'b0;
          if_gnt     <= 1'b0;
          d_gnt      <= 1'b0;
          last_owner <= owner;
          if (owner == OWN_DATA) begin
            lock_hold <= lock_req;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb: a LAT=2 instance for the main scenarios
// and a LAT=1 instance for the short-latency build.
module tb_sisc_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_req = 0, d_req = 0, d_we = 0, d_lock = 0;
  logic [15:0] if_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic        if_gnt, if_done, d_gnt, d_done, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic        b_if_req = 0, b_d_req = 0, b_d_we = 0, b_d_lock = 0;
  logic [15:0] b_if_addr = 0, b_d_addr = 0;
  logic [31:0] b_d_wdata = 0;
  logic        b_if_gnt, b_if_done, b_d_gnt, b_d_done, b_mem_en, b_mem_we;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_mem_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sisc_mem_arb #(.AW(16), .DW(32), .LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  sisc_mem_arb #(.AW(16), .DW(32), .LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_lock(b_d_lock), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Memory models: preset contents plus write-back storage, read data
  // valid exactly LAT cycles after the strobe cycle and garbage otherwise.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 32'h8A00_0001;
      8'h30:   return 32'h1234_5678;
      8'h40:   return 32'h4040_4040;
      default: return 32'h0;
    endcase
  endfunction

  bit [31:0]  mem_a [256];
  bit [255:0] wv_a;
  bit [31:0]  pa0, pa1;
  bit [31:0]  mem_b [256];
  bit [255:0] wv_b;
  bit [31:0]  pb0;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_a[mem_addr[7:0]] <= mem_wdata;
      wv_a[mem_addr[7:0]]  <= 1'b1;
    end
    pa0 <= (mem_en && !mem_we) ? (wv_a[mem_addr[7:0]] ? mem_a[mem_addr[7:0]] : init_val(mem_addr[7:0]))
                               : 32'hEEEE_EEEE;
    pa1 <= pa0;
    if (b_mem_en && b_mem_we) begin
      mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
      wv_b[b_mem_addr[7:0]]  <= 1'b1;
    end
    pb0 <= (b_mem_en && !b_mem_we) ? (wv_b[b_mem_addr[7:0]] ? mem_b[b_mem_addr[7:0]] : init_val(b_mem_addr[7:0]))
                                   : 32'hEEEE_EEEE;
  end

  assign mem_rdata   = pa1;
  assign b_mem_rdata = pb0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_excl(input string tag);
    check({tag, "_gnt_excl"}, 32'(if_gnt & d_gnt), 32'd0);
    check({tag, "_fetch_no_we"}, 32'(if_gnt & mem_we), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_if_gnt", 32'(if_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    // 1: fetch only
    if_req = 1; if_addr = 16'h0010;
    tick();
    check("t1_if_gnt", 32'(if_gnt), 1);
    check("t1_mem_en", 32'(mem_en), 1);
    check("t1_mem_addr", 32'(mem_addr), 32'h10);
    check("t1_mem_we", 32'(mem_we), 0);
    tick();
    check("t1_mem_en_off", 32'(mem_en), 0);
    check("t1_no_done_e1", 32'(if_done), 0);
    tick();
    check("t1_no_done_e2", 32'(if_done), 0);
    tick();
    check("t1_if_done", 32'(if_done), 1);
    check("t1_if_rdata", if_rdata, 32'h8A00_0001);
    check("t1_d_gnt", 32'(d_gnt), 0);
    check("t1_d_done", 32'(d_done), 0);
    if_req = 0;
    tick();
    check("t1_idle_gnt", 32'(if_gnt), 0);
    check("t1_done_pulse", 32'(if_done), 0);
    tick();

    // 2: store
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("t2_d_gnt", 32'(d_gnt), 1);
    check("t2_mem_en", 32'(mem_en), 1);
    check("t2_mem_we", 32'(mem_we), 1);
    check("t2_mem_addr", 32'(mem_addr), 32'h20);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("t2_mem_we_hold", 32'(mem_we), 1);
    check("t2_mem_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("t2_no_done", 32'(d_done), 0);
    tick();
    check("t2_d_done", 32'(d_done), 1);
    check("t2_d_rdata_keep", d_rdata, 32'h0);
    check("t2_if_rdata_keep", if_rdata, 32'h8A00_0001);
    d_req = 0; d_we = 0;
    tick();
    check("t2_done_pulse", 32'(d_done), 0);
    check("t2_idle_gnt", 32'(d_gnt), 0);

    // 3: simultaneous requests after reset, round-robin
    rst = 1; tick(); rst = 0;
    if_req = 1; if_addr = 16'h0010;
    d_req = 1; d_we = 0; d_addr = 16'h0020;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_excl($sformatf("t3_c%0d", i));
      case (i)
        1:  begin check("t3_fetch_first", 32'(if_gnt), 1); check("t3_d_wait", 32'(d_gnt), 0); end
        4:  check("t3_if_rdata", if_rdata, 32'h8A00_0001);
        5:  check("t3_gap", 32'(if_gnt | d_gnt), 0);
        6:  check("t3_data_second", 32'(d_gnt), 1);
        9:  begin check("t3_d_done", 32'(d_done), 1); check("t3_d_rdata", d_rdata, 32'hDEAD_BEEF); end
        11: begin check("t3_fetch_third", 32'(if_gnt), 1); if_req = 0; d_req = 0; end
        14: check("t3_if_done3", 32'(if_done), 1);
        15: check("t3_idle", 32'(if_gnt | d_gnt), 0);
        default: ;
      endcase
    end

    // 4: SWP lock keeps the port on the data side
    if_req = 1; if_addr = 16'h0010;
    d_req = 1; d_we = 0; d_lock = 1; d_addr = 16'h0030;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_excl($sformatf("t4_c%0d", i));
      case (i)
        1:  check("t4_load_gnt", 32'(d_gnt), 1);
        4:  begin
              check("t4_load_rdata", d_rdata, 32'h1234_5678);
              d_we = 1; d_lock = 0; d_wdata = 32'hCAFE_F00D;
            end
        6:  begin
              check("t4_store_before_fetch", 32'(d_gnt), 1);
              check("t4_store_we", 32'(mem_we), 1);
              check("t4_store_wdata", mem_wdata, 32'hCAFE_F00D);
            end
        9:  begin check("t4_store_done", 32'(d_done), 1); d_req = 0; d_we = 0; end
        11: begin
              check("t4_fetch_after", 32'(if_gnt), 1);
              check("t4_fetch_addr", 32'(mem_addr), 32'h10);
              if_req = 0;
            end
        14: check("t4_if_done", 32'(if_done), 1);
        default: ;
      endcase
    end

    // 5: reset in the second ACCESS cycle
    if_req = 1; if_addr = 16'h0010;
    tick();
    check("t5_gnt", 32'(if_gnt), 1);
    tick();
    rst = 1;
    #1;
    check("t5_async_gnt", 32'(if_gnt), 0);
    check("t5_async_addr", 32'(mem_addr), 0);
    check("t5_async_rdata", if_rdata, 0);
    d_req = 1; d_we = 0; d_addr = 16'h0030;
    tick();
    check("t5_no_done", 32'(if_done), 0);
    rst = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_excl($sformatf("t5_c%0d", i));
      case (i)
        1:  begin check("t5_fetch_prio", 32'(if_gnt), 1); check("t5_data_wait", 32'(d_gnt), 0); end
        4:  begin check("t5_if_rdata", if_rdata, 32'h8A00_0001); if_req = 0; end
        6:  check("t5_data_gnt", 32'(d_gnt), 1);
        9:  begin check("t5_d_rdata", d_rdata, 32'hCAFE_F00D); d_req = 0; end
        10: check("t5_idle", 32'(d_gnt), 0);
        default: ;
      endcase
    end

    // 6: LAT=1 instance
    b_d_req = 1; b_d_we = 0; b_d_addr = 16'h0040;
    tick();
    check("t6_gnt", 32'(b_d_gnt), 1);
    check("t6_mem_en", 32'(b_mem_en), 1);
    tick();
    check("t6_mem_en_off", 32'(b_mem_en), 0);
    check("t6_no_done", 32'(b_d_done), 0);
    tick();
    check("t6_done", 32'(b_d_done), 1);
    check("t6_rdata", b_d_rdata, 32'h4040_4040);
    b_d_req = 0;
    tick();
    check("t6_done_pulse", 32'(b_d_done), 0);
    check("t6_mem_en_idle", 32'(b_mem_en), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
